// File: rtl/unidade_controle_if.sv
// unidade_controle_if: status inputs and control/debug outputs between the memory-game FSM and its datapath
interface unidade_controle_if #(parameter int DB_W = 5);
    logic iniciar, jogada_feita, chavesIgualMemoria, enderecoIgualSequencia, fimL, fimTMR, timeout;
    logic zeraE, zeraL, zeraR, zeraM, zeraTMR;
    logic contaE, contaL, contaTMR;
    logic registraR, registraM;
    logic pronto, ganhou, perdeu;
    logic [DB_W-1:0] db_estado;
    modport master (
        output iniciar, jogada_feita, chavesIgualMemoria, enderecoIgualSequencia, fimL, fimTMR, timeout,
        input zeraE, zeraL, zeraR, zeraM, zeraTMR, contaE, contaL, contaTMR,
        input registraR, registraM, pronto, ganhou, perdeu, db_estado
    );
    modport slave (
        input iniciar, jogada_feita, chavesIgualMemoria, enderecoIgualSequencia, fimL, fimTMR, timeout,
        output zeraE, zeraL, zeraR, zeraM, zeraTMR, contaE, contaL, contaTMR,
        output registraR, registraM, pronto, ganhou, perdeu, db_estado
    );
endinterface

// File: rtl/unidade_controle.sv
// unidade_controle: Moore FSM sequencing the memory-game datapath (display rounds, move checking).
// Define TIMEOUT_EN to let a move timeout in espera_jogada end the game in fim_timeout.
module unidade_controle #(parameter int DB_W = 5) (
    input logic clock,
    input logic reset_n,
    unidade_controle_if.slave bus
);
    typedef enum logic [3:0] {
        inicial, preparacao, inicio_seq, mostra, proximo_mostra, incr_mostra, fim_mostra, espera_jogada,
        registra, comparacao, proxima_jogada, ultima_jogada, proxima_seq, fim_acertou, fim_errou, fim_timeout
    } state_t;
    state_t state, nxt;
    // {zeraE,zeraL,zeraR,zeraM,zeraTMR,contaE,contaL,contaTMR,registraR,registraM,pronto,ganhou,perdeu}
    function automatic logic [12:0] decode(state_t s);
        case (s)
            preparacao:     return 13'b11111_000_00_000;
            inicio_seq:     return 13'b10001_000_00_000;
            mostra:         return 13'b00000_001_01_000;
            proximo_mostra: return 13'b00011_000_00_000;
            incr_mostra:    return 13'b00000_100_00_000;
            fim_mostra:     return 13'b10100_000_00_000;
            registra:       return 13'b00000_000_10_000;
            proxima_jogada: return 13'b00000_100_00_000;
            proxima_seq:    return 13'b00000_010_00_000;
            fim_acertou:    return 13'b00000_000_00_110;
            fim_errou:      return 13'b00000_000_00_101;
`ifdef TIMEOUT_EN
            fim_timeout:    return 13'b00000_000_00_101;
`endif
            default:        return 13'b0;
        endcase
    endfunction
    always_comb begin
        nxt = inicial;
        case (state)
            inicial:        nxt = bus.iniciar ? preparacao : inicial;
            preparacao:     nxt = inicio_seq;
            inicio_seq:     nxt = mostra;
            mostra:         nxt = bus.fimTMR ? proximo_mostra : mostra;
            proximo_mostra: nxt = bus.enderecoIgualSequencia ? fim_mostra : incr_mostra;
            incr_mostra:    nxt = mostra;
            fim_mostra:     nxt = espera_jogada;
`ifdef TIMEOUT_EN
            espera_jogada:  nxt = bus.jogada_feita ? registra : bus.timeout ? fim_timeout : espera_jogada;
            fim_timeout:    nxt = bus.iniciar ? preparacao : fim_timeout;
`else
            espera_jogada:  nxt = bus.jogada_feita ? registra : espera_jogada;
`endif
            registra:       nxt = comparacao;
            comparacao:     nxt = !bus.chavesIgualMemoria ? fim_errou :
                                  bus.enderecoIgualSequencia ? ultima_jogada : proxima_jogada;
            proxima_jogada: nxt = espera_jogada;
            ultima_jogada:  nxt = bus.fimL ? fim_acertou : proxima_seq;
            proxima_seq:    nxt = inicio_seq;
            fim_acertou:    nxt = bus.iniciar ? preparacao : fim_acertou;
            fim_errou:      nxt = bus.iniciar ? preparacao : fim_errou;
            default:        nxt = inicial;
        endcase
    end
    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= inicial;
            {bus.zeraE, bus.zeraL, bus.zeraR, bus.zeraM, bus.zeraTMR, bus.contaE, bus.contaL, bus.contaTMR,
             bus.registraR, bus.registraM, bus.pronto, bus.ganhou, bus.perdeu} <= '0;
            bus.db_estado <= '0;
        end else begin
            state <= nxt;
            {bus.zeraE, bus.zeraL, bus.zeraR, bus.zeraM, bus.zeraTMR, bus.contaE, bus.contaL, bus.contaTMR,
             bus.registraR, bus.registraM, bus.pronto, bus.ganhou, bus.perdeu} <= decode(nxt);
            bus.db_estado <= DB_W'(nxt);
        end
    end
endmodule
